// File: rtl/mealy_det_pkg.sv
// Shared constants and the elaboration-time prefix/suffix fallback helper
// for the non-overlapping Mealy sequence detector.
package mealy_det_pkg;

  localparam int SEQ_LEN_MAX = 8;
  localparam int ST_W        = $clog2(SEQ_LEN_MAX);
  localparam int CNT_W       = 8;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t S0 = '0;

  // Next state after receiving xb in state k (k bits matched).
  // Pattern bit i (0 = first received) is seq[len-1-i].
  function automatic state_t seq_next(input int len,
                                      input logic [SEQ_LEN_MAX-1:0] seq,
                                      input int k,
                                      input logic xb);
    logic [SEQ_LEN_MAX:0] rcv;
    logic                 ok;
    int                   best;
    rcv  = '0;
    best = 0;
    for (int i = 0; i < SEQ_LEN_MAX; i++)
      if (i < k) rcv[i] = seq[len-1-i];
    rcv[k] = xb;
    if (xb == seq[len-1-k]) begin
      best = (k == len-1) ? 0 : k + 1;
    end else begin
      // ascending scan, so the last hit is the longest border
      for (int l = 1; l <= SEQ_LEN_MAX; l++) begin
        if (l <= k) begin
          ok = 1'b1;
          for (int j = 0; j < SEQ_LEN_MAX; j++)
            if (j < l && rcv[k+1-l+j] != seq[len-1-j]) ok = 1'b0;
          if (ok) best = l;
        end
      end
    end
    return state_t'(best);
  endfunction

endpackage

// File: rtl/mealy_non_overlap_if.sv
// Serial detector bus: input bit x, Mealy flag z, optional match_cnt
// (present when DET_COUNT_EN is defined).
interface mealy_non_overlap_if;
  import mealy_det_pkg::*;

  logic             x;
  logic             z;
`ifdef DET_COUNT_EN
  logic [CNT_W-1:0] match_cnt;

  modport master (output x, input  z, input  match_cnt);
  modport slave  (input  x, output z, output match_cnt);
`else
  modport master (output x, input  z);
  modport slave  (input  x, output z);
`endif

endinterface

// File: rtl/mealy_non_overlap_seq_fallback.sv
// Combinational next-state map (state, x) -> state; table is derived from
// SEQ at elaboration, match from the last state returns to S0.
module seq_fallback
  import mealy_det_pkg::*;
#(
  parameter int                 SEQ_LEN = 4,
  parameter logic [SEQ_LEN-1:0] SEQ     = SEQ_LEN'(4'b1011)
) (
  input  state_t state,
  input  logic   x,
  output state_t nxt
);

  localparam logic [SEQ_LEN_MAX-1:0] SEQ_X = SEQ_LEN_MAX'(SEQ);

  state_t tbl0 [SEQ_LEN];
  state_t tbl1 [SEQ_LEN];

  for (genvar k = 0; k < SEQ_LEN; k++) begin : g_tbl
    assign tbl0[k] = seq_next(SEQ_LEN, SEQ_X, k, 1'b0);
    assign tbl1[k] = seq_next(SEQ_LEN, SEQ_X, k, 1'b1);
  end

  // unreachable encodings fall back to idle
  always_comb begin
    nxt = S0;
    for (int k = 0; k < SEQ_LEN; k++)
      if (state == state_t'(k)) nxt = x ? tbl1[k] : tbl0[k];
  end

endmodule

// File: rtl/mealy_non_overlap.sv
// Non-overlapping Mealy sequence detector: state register, combinational
// match flag, and saturating match counter when DET_COUNT_EN is defined.
module mealy_non_overlap
  import mealy_det_pkg::*;
#(
  parameter int                 SEQ_LEN = 4,
  parameter logic [SEQ_LEN-1:0] SEQ     = SEQ_LEN'(4'b1011)
) (
  input  logic                clk,
  input  logic                rst_n,
  mealy_non_overlap_if.slave  bus
);

  localparam state_t LAST = state_t'(SEQ_LEN - 1);

  state_t state, state_d, fb_nxt;

  seq_fallback #(.SEQ_LEN(SEQ_LEN), .SEQ(SEQ)) u_fb (
    .state (state),
    .x     (bus.x),
    .nxt   (fb_nxt)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S0;
    else        state <= state_d;

  always_comb begin
    state_d = fb_nxt;
    bus.z   = (state == LAST) && (bus.x == SEQ[0]);
  end

`ifdef DET_COUNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                    cnt <= '0;
    else if (bus.z && (cnt != '1)) cnt <= cnt + 1'b1;

  assign bus.match_cnt = cnt;
`endif

endmodule

// File: tb/tb_mealy_non_overlap.sv
// Directed bench for mealy_non_overlap: default 1011 detector plus a
// SEQ_LEN=3 / 110 instance; counter checks when DET_COUNT_EN is defined.
module tb_mealy_non_overlap;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  mealy_non_overlap_if bus0();
  mealy_non_overlap_if bus1();

  mealy_non_overlap u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  mealy_non_overlap #(.SEQ_LEN(3), .SEQ(3'b110)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // x changes on the falling edge; z sampled 1 ns later, before the capture edge
  task automatic send0(input logic b, input logic ez, input string tag);
    @(negedge clk);
    bus0.x = b;
    #1 chk(tag, {31'b0, bus0.z}, {31'b0, ez});
  endtask

  task automatic send1(input logic b, input logic ez, input string tag);
    @(negedge clk);
    bus1.x = b;
    #1 chk(tag, {31'b0, bus1.z}, {31'b0, ez});
  endtask

  initial begin
    logic [11:0] xs;
    logic [11:0] zs;
    logic [6:0]  xs1;
    logic [6:0]  zs1;
    logic [5:0]  xf;
    logic [5:0]  zf;
    logic [3:0]  xp;
    logic [3:0]  zp;

    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus0.x = 1'b0;
    bus1.x = 1'b0;

    #2;
    chk("rst_z0", {31'b0, bus0.z}, 32'd0);
    chk("rst_z1", {31'b0, bus1.z}, 32'd0);
`ifdef DET_COUNT_EN
    chk("rst_cnt", 32'(bus0.match_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // SEQ=110: 1,1,1,0,1,1,0 -> hits on bits 4 and 7
    xs1 = 7'b1110110;
    zs1 = 7'b0001001;
    for (int i = 6; i >= 0; i--)
      send1(xs1[i], zs1[i], $sformatf("p3_b%0d", 7 - i));
    send1(1'b0, 1'b0, "p3_idle");
`ifdef DET_COUNT_EN
    chk("p3_cnt", 32'(bus1.match_cnt), 32'd2);
`endif

    // default stream: overlapping candidate at bit 8 must not fire
    xs = 12'b010110110110;
    zs = 12'b000010000010;
    for (int i = 11; i >= 0; i--)
      send0(xs[i], zs[i], $sformatf("s1_b%0d", 12 - i));
`ifdef DET_COUNT_EN
    @(negedge clk);
    chk("s1_cnt", 32'(bus0.match_cnt), 32'd2);
`endif

    // S3 receiving 0 must fall back to S2, not S0
    xf = 6'b101011;
    zf = 6'b000001;
    for (int i = 5; i >= 0; i--)
      send0(xf[i], zf[i], $sformatf("fb_b%0d", 6 - i));

    // reach S3 then toggle x within one low phase
    send0(1'b1, 1'b0, "mt_1");
    send0(1'b0, 1'b0, "mt_2");
    send0(1'b1, 1'b0, "mt_3");
    @(negedge clk);
    bus0.x = 1'b0;
    #1 chk("mt_x0", {31'b0, bus0.z}, 32'd0);
    bus0.x = 1'b1;
    #1 chk("mt_x1", {31'b0, bus0.z}, 32'd1);
    bus0.x = 1'b0;
    #1 chk("mt_x0b", {31'b0, bus0.z}, 32'd0);
    // the 0 is captured -> S2; then 1 -> S3
    send0(1'b1, 1'b0, "mt_s3");

    // async reset while in S3 with x completing the pattern
    @(negedge clk);
    bus0.x = 1'b1;
    #1 chk("pre_rst_z", {31'b0, bus0.z}, 32'd1);
`ifdef DET_COUNT_EN
    chk("pre_rst_cnt", 32'(bus0.match_cnt), 32'd3);
`endif
    rst_n = 1'b0;
    #1 chk("mid_rst_z", {31'b0, bus0.z}, 32'd0);
`ifdef DET_COUNT_EN
    chk("mid_rst_cnt", 32'(bus0.match_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n  = 1'b1;
    bus0.x = 1'b0;

    xp = 4'b1011;
    zp = 4'b0001;
    for (int i = 3; i >= 0; i--)
      send0(xp[i], zp[i], $sformatf("post_rst_b%0d", 4 - i));
`ifdef DET_COUNT_EN
    @(negedge clk);
    chk("post_rst_cnt", 32'(bus0.match_cnt), 32'd1);

    // 300 back-to-back patterns: counter pins at 255, z keeps pulsing
    for (int p = 0; p < 300; p++) begin
      for (int i = 3; i >= 0; i--)
        send0(xp[i], zp[i], $sformatf("sat_p%0d_b%0d", p, 4 - i));
      if (p == 252) begin
        @(negedge clk);
        chk("sat_cnt254", 32'(bus0.match_cnt), 32'd254);
      end
      if (p == 253) begin
        @(negedge clk);
        chk("sat_cnt255", 32'(bus0.match_cnt), 32'd255);
      end
    end
    @(negedge clk);
    chk("sat_cnt_hold", 32'(bus0.match_cnt), 32'd255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
